// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass and a per-register
// pending-write scoreboard for RAW hazard stalls.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     busy_any,
  output logic                     err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [PEND_W-1:0] cnt     [DEPTH];
  logic [PEND_W-1:0] cnt_nxt [DEPTH];

  logic wr_live;
  logic iss_fire;
  logic iss_err;
  logic wr_err;

  assign wr_live   = wr_en && (wr_addr != '0);
  assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != CNT_MAX);
  assign iss_fire  = iss_en && iss_ready && (iss_addr != '0);
  assign iss_err   = iss_en && !iss_ready;
  assign wr_err    = wr_live && (cnt[wr_addr] == '0);

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      logic inc;
      logic dec;
      cnt_nxt[a] = cnt[a];
      inc = iss_fire && (iss_addr == ADDR_W'(a));
      dec = wr_live && (wr_addr == ADDR_W'(a)) && (cnt[a] != '0);
      unique case (1'b1)
        inc && !dec: cnt_nxt[a] = cnt[a] + PEND_W'(1);
        dec && !inc: cnt_nxt[a] = cnt[a] - PEND_W'(1);
        default:     cnt_nxt[a] = cnt[a];
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs[a] <= '0;
        cnt[a]  <= '0;
      end
      err <= 1'b0;
    end else begin
      if (wr_live) regs[wr_addr] <= wr_data;
      for (int a = 1; a < DEPTH; a++) cnt[a] <= cnt_nxt[a];
      if (iss_err || wr_err) err <= 1'b1;
    end
  end

  // A retire of the last pending write clears busy: the bypass supplies the value.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic              hit;
      a   = rd_addr[i*ADDR_W +: ADDR_W];
      hit = wr_live && (wr_addr == a);
      rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : regs[a];
      rd_busy[i] = (cnt[a] != '0) && !(hit && (cnt[a] == PEND_W'(1)));
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int a = 0; a < DEPTH; a++) busy_any = busy_any | (cnt[a] != '0);
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        busy_any;
  logic        err;

  logic [4:0]  ra0, ra1;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign rd_addr = {ra1, ra0};

  regfile_scoreboard dut (
    .clock(clock), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy_any(busy_any), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0;
    wr_en  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; idle();
    iss_addr = '0; wr_addr = '0; wr_data = '0;
    dbg_addr = '0; ra0 = '0; ra1 = '0;
    step(); step();
    reset = 1'b1;
    #2;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #0.1;
      chk($sformatf("rst_dbg%0d", a), dbg_data, 32'h0);
    end
    chk("rst_busy", {30'b0, rd_busy}, 32'h0);
    chk("rst_busy_any", {31'b0, busy_any}, 32'h0);
    chk("rst_iss_ready", {31'b0, iss_ready}, 32'h1);
    chk("rst_err", {31'b0, err}, 32'h0);

    // register 0 stays zero and never tracks
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd0; ra0 = 5'd0; dbg_addr = 5'd0;
    #2;
    chk("r0_iss_ready", {31'b0, iss_ready}, 32'h1);
    chk("r0_rd_data", rd_data[31:0], 32'h0);
    chk("r0_busy", {30'b0, rd_busy}, 32'h0);
    step(); idle(); #2;
    chk("r0_dbg", dbg_data, 32'h0);
    chk("r0_busy_any", {31'b0, busy_any}, 32'h0);
    chk("r0_err", {31'b0, err}, 32'h0);

    // bypass on an untracked write, which also flags err
    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    ra0 = 5'd5; dbg_addr = 5'd5;
    #2;
    chk("byp_rd0", rd_data[31:0], 32'hDEAD_BEEF);
    chk("byp_dbg_old", dbg_data, 32'h0);
    step(); idle(); #2;
    chk("byp_dbg_new", dbg_data, 32'hDEAD_BEEF);
    chk("unissued_wr_err", {31'b0, err}, 32'h1);

    reset = 1'b0; step(); reset = 1'b1; #2;
    chk("rst2_err", {31'b0, err}, 32'h0);
    chk("rst2_dbg5", dbg_data, 32'h0);

    // issue 7, then retire it with bypass
    iss_en = 1'b1; iss_addr = 5'd7;
    step(); idle(); ra1 = 5'd7; #2;
    chk("r7_busy1", {31'b0, rd_busy[1]}, 32'h1);
    chk("r7_busy_any", {31'b0, busy_any}, 32'h1);
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; #2;
    chk("r7_retire_busy1", {31'b0, rd_busy[1]}, 32'h0);
    chk("r7_retire_data1", rd_data[63:32], 32'h1234);
    chk("r7_retire_busy_any", {31'b0, busy_any}, 32'h1);
    step(); idle(); dbg_addr = 5'd7; #2;
    chk("r7_busy_any_after", {31'b0, busy_any}, 32'h0);
    chk("r7_dbg", dbg_data, 32'h1234);
    chk("r7_err", {31'b0, err}, 32'h0);

    // saturate reg 3
    iss_en = 1'b1; iss_addr = 5'd3; ra0 = 5'd3;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("r3_ready%0d", k), {31'b0, iss_ready}, 32'h1);
      step();
    end
    #2;
    chk("r3_full", {31'b0, iss_ready}, 32'h0);
    chk("r3_err_before", {31'b0, err}, 32'h0);
    step(); idle(); #2;
    chk("r3_err", {31'b0, err}, 32'h1);
    chk("r3_busy0", {31'b0, rd_busy[0]}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd3;
    for (int k = 0; k < 3; k++) begin
      wr_data = 32'(k + 1);
      #2;
      if (k == 0)
        chk("r3_ready_no_raise", {31'b0, iss_ready}, 32'h0);
      chk($sformatf("r3_wr_busy%0d", k), {31'b0, rd_busy[0]},
          (k == 2) ? 32'h0 : 32'h1);
      step();
    end
    idle(); #2;
    chk("r3_busy_done", {31'b0, rd_busy[0]}, 32'h0);
    chk("r3_busy_any_done", {31'b0, busy_any}, 32'h0);
    chk("r3_ready_done", {31'b0, iss_ready}, 32'h1);

    // issue and write 9 together keeps the count
    iss_en = 1'b1; iss_addr = 5'd9; ra0 = 5'd9;
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA; #2;
    chk("r9_same_busy", {31'b0, rd_busy[0]}, 32'h0);
    step(); idle(); dbg_addr = 5'd9; #2;
    chk("r9_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("r9_busy_any", {31'b0, busy_any}, 32'h1);
    chk("r9_dbg", dbg_data, 32'hAA);
    reset = 1'b0; step(); reset = 1'b1; #2;
    chk("r9_rst_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("r9_rst_busy_any", {31'b0, busy_any}, 32'h0);
    chk("r9_rst_dbg", dbg_data, 32'h0);
    chk("r9_rst_err", {31'b0, err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
